// File: rtl/us_seq_pkg.sv
// Shared definitions for the ultrasound scan sequencer: default widths and
// the one-hot state encoding of the scan FSM.
package us_seq_pkg;

    localparam int DEF_CH_WIDTH  = 4;
    localparam int DEF_AVG_WIDTH = 8;
    localparam int DEF_PRI_WIDTH = 32;
    localparam int DEF_TMO_WIDTH = 32;

    // One-hot state codes
    localparam logic [7:0] ST_IDLE_OH      = 8'b0000_0001;
    localparam logic [7:0] ST_ARM_OH       = 8'b0000_0010;
    localparam logic [7:0] ST_FIRE_OH      = 8'b0000_0100;
    localparam logic [7:0] ST_WAIT_ACK_OH  = 8'b0000_1000;
    localparam logic [7:0] ST_WAIT_DONE_OH = 8'b0001_0000;
    localparam logic [7:0] ST_PRI_OH       = 8'b0010_0000;
    localparam logic [7:0] ST_NEXT_OH      = 8'b0100_0000;
    localparam logic [7:0] ST_FINISH_OH    = 8'b1000_0000;

    typedef enum logic [7:0] {
        ST_IDLE      = ST_IDLE_OH,
        ST_ARM       = ST_ARM_OH,
        ST_FIRE      = ST_FIRE_OH,
        ST_WAIT_ACK  = ST_WAIT_ACK_OH,
        ST_WAIT_DONE = ST_WAIT_DONE_OH,
        ST_PRI       = ST_PRI_OH,
        ST_NEXT      = ST_NEXT_OH,
        ST_FINISH    = ST_FINISH_OH
    } seq_state_t;

endpackage

// File: rtl/us_scan_sequencer_if.sv
// Handshake between the scan sequencer (master) and the single-shot firing
// FSM (slave): start pulse, done level and the channel/shot selection.
interface us_scan_sequencer_if #(
    parameter int CH_WIDTH  = 4,
    parameter int AVG_WIDTH = 8
);
    logic                 FIRE_START;
    logic                 FIRE_DONE;
    logic [CH_WIDTH-1:0]  CH_SEL;
    logic [AVG_WIDTH-1:0] AVG_IDX;

    modport master (
        output FIRE_START,
        output CH_SEL,
        output AVG_IDX,
        input  FIRE_DONE
    );

    modport slave (
        input  FIRE_START,
        input  CH_SEL,
        input  AVG_IDX,
        output FIRE_DONE
    );
endinterface

// File: rtl/us_seq_index_ctr.sv
// Nested channel / averaging index counter. The averaging index is the inner
// loop; the channel index advances when the averaging index wraps. The pair
// holds (no wrap) once the last shot of the scan has been reached.
module us_seq_index_ctr #(
    parameter int CH_WIDTH  = 4,
    parameter int AVG_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic [CH_WIDTH-1:0]  num_ch,
    input  logic [AVG_WIDTH-1:0] avg_count,
    output logic [CH_WIDTH-1:0]  ch_sel,
    output logic [AVG_WIDTH-1:0] avg_idx,
    output logic                 last_shot
);

    localparam logic [CH_WIDTH-1:0]  CH_ZERO  = {CH_WIDTH{1'b0}};
    localparam logic [CH_WIDTH-1:0]  CH_ONE   = {{(CH_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AVG_WIDTH-1:0] AVG_ZERO = {AVG_WIDTH{1'b0}};
    localparam logic [AVG_WIDTH-1:0] AVG_ONE  = {{(AVG_WIDTH-1){1'b0}}, 1'b1};

    logic [CH_WIDTH-1:0]  ch_sel_r;
    logic [AVG_WIDTH-1:0] avg_idx_r;
    logic                 ch_last_s;
    logic                 avg_last_s;

    // Limit detection against latched counts minus one, at full width
    always_comb begin
        ch_last_s  = (ch_sel_r == (num_ch - CH_ONE));
        avg_last_s = (avg_idx_r == (avg_count - AVG_ONE));
    end

    assign last_shot = ch_last_s & avg_last_s;
    assign ch_sel    = ch_sel_r;
    assign avg_idx   = avg_idx_r;

    // Index registers: cleared on load, stepped on advance, frozen at the end
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ch_sel_r  <= CH_ZERO;
            avg_idx_r <= AVG_ZERO;
        end else if (load) begin
            ch_sel_r  <= CH_ZERO;
            avg_idx_r <= AVG_ZERO;
        end else if (advance && !(ch_last_s && avg_last_s)) begin
            if (!avg_last_s) begin
                avg_idx_r <= avg_idx_r + AVG_ONE;
            end else begin
                avg_idx_r <= AVG_ZERO;
                ch_sel_r  <= ch_sel_r + CH_ONE;
            end
        end else begin
            ch_sel_r  <= ch_sel_r;
            avg_idx_r <= avg_idx_r;
        end
    end

endmodule

// File: rtl/us_scan_sequencer.sv
// Ultrasound scan sequencer: fires each of NUM_CH channels AVG_COUNT times via
// the single-shot firing FSM, with a PRI gap between shots, abort handling and
// a done pulse at the end of the scan.
// Optional watchdog on the firing handshake: define SEQ_TIMEOUT_EN.
module us_scan_sequencer
    import us_seq_pkg::*;
#(
    parameter int CH_WIDTH  = DEF_CH_WIDTH,
    parameter int AVG_WIDTH = DEF_AVG_WIDTH,
    parameter int PRI_WIDTH = DEF_PRI_WIDTH,
    parameter int TMO_WIDTH = DEF_TMO_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic                 SEQ_START,
    input  logic                 SEQ_ABORT,
    input  logic [CH_WIDTH-1:0]  NUM_CH,
    input  logic [AVG_WIDTH-1:0] AVG_COUNT,
    input  logic [PRI_WIDTH-1:0] PRI_LENGTH,
    input  logic [TMO_WIDTH-1:0] TMO_LENGTH,
    us_scan_sequencer_if.master  fire_if,
    output logic                 SEQ_BUSY,
    output logic                 SEQ_DONE,
    output logic                 SEQ_ABORTED,
    output logic                 SEQ_ERR
);

    localparam logic [CH_WIDTH-1:0]  CH_ZERO  = {CH_WIDTH{1'b0}};
    localparam logic [AVG_WIDTH-1:0] AVG_ZERO = {AVG_WIDTH{1'b0}};
    localparam logic [PRI_WIDTH-1:0] PRI_ZERO = {PRI_WIDTH{1'b0}};
    localparam logic [PRI_WIDTH-1:0] PRI_ONE  = {{(PRI_WIDTH-1){1'b0}}, 1'b1};

    seq_state_t           state_r;
    logic [CH_WIDTH-1:0]  num_ch_r;
    logic [AVG_WIDTH-1:0] avg_cnt_r;
    logic [PRI_WIDTH-1:0] pri_len_r;
    logic [PRI_WIDTH-1:0] pri_cnt_r;
    logic                 abort_r;
    logic                 fire_start_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 aborted_r;

    logic                 abort_now_s;
    logic                 idx_load_s;
    logic                 idx_adv_s;
    logic                 last_shot_s;
    logic                 wd_trip_s;
    logic [CH_WIDTH-1:0]  ch_sel_s;
    logic [AVG_WIDTH-1:0] avg_idx_s;

    // Strobes into the index counter and the effective abort request
    always_comb begin
        idx_load_s  = (state_r == ST_ARM);
        idx_adv_s   = (state_r == ST_NEXT);
        abort_now_s = abort_r | SEQ_ABORT;
    end

    us_seq_index_ctr #(
        .CH_WIDTH  (CH_WIDTH),
        .AVG_WIDTH (AVG_WIDTH)
    ) u_index_ctr (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .load      (idx_load_s),
        .advance   (idx_adv_s),
        .num_ch    (num_ch_r),
        .avg_count (avg_cnt_r),
        .ch_sel    (ch_sel_s),
        .avg_idx   (avg_idx_s),
        .last_shot (last_shot_s)
    );

    // Scan FSM with registered FIRE_START / busy / done / aborted outputs
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r      <= ST_IDLE;
            num_ch_r     <= CH_ZERO;
            avg_cnt_r    <= AVG_ZERO;
            pri_len_r    <= PRI_ZERO;
            pri_cnt_r    <= PRI_ZERO;
            abort_r      <= 1'b0;
            fire_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
        end else begin
            fire_start_r <= 1'b0;
            done_r       <= 1'b0;
            if ((state_r != ST_IDLE) && SEQ_ABORT) begin
                abort_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (SEQ_START) begin
                        state_r <= ST_ARM;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    num_ch_r  <= NUM_CH;
                    avg_cnt_r <= AVG_COUNT;
                    pri_len_r <= PRI_LENGTH;
                    aborted_r <= 1'b0;
                    abort_r   <= SEQ_ABORT;
                    // Decide on the raw inputs: they are being latched this cycle
                    if ((NUM_CH == CH_ZERO) || (AVG_COUNT == AVG_ZERO)) begin
                        state_r <= ST_FINISH;
                        done_r  <= 1'b1;
                    end else begin
                        state_r      <= ST_FIRE;
                        fire_start_r <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    state_r <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!fire_if.FIRE_DONE) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (wd_trip_s) begin
                        state_r <= ST_FINISH;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_DONE: begin
                    if (fire_if.FIRE_DONE) begin
                        if (abort_now_s) begin
                            // Shot finished; an abort skips the PRI gap
                            state_r   <= ST_FINISH;
                            done_r    <= 1'b1;
                            aborted_r <= 1'b1;
                        end else if (pri_len_r == PRI_ZERO) begin
                            state_r <= ST_NEXT;
                        end else begin
                            state_r   <= ST_PRI;
                            pri_cnt_r <= pri_len_r;
                        end
                    end else if (wd_trip_s) begin
                        state_r <= ST_FINISH;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_PRI: begin
                    if (abort_now_s) begin
                        state_r   <= ST_FINISH;
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                    end else if (pri_cnt_r == PRI_ONE) begin
                        state_r <= ST_NEXT;
                    end else begin
                        pri_cnt_r <= pri_cnt_r - PRI_ONE;
                    end
                end
                ST_NEXT: begin
                    // Completing the last shot wins over a coincident abort
                    if (last_shot_s) begin
                        state_r <= ST_FINISH;
                        done_r  <= 1'b1;
                    end else if (abort_now_s) begin
                        state_r   <= ST_FINISH;
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                    end else begin
                        state_r      <= ST_FIRE;
                        fire_start_r <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    abort_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    abort_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [TMO_WIDTH-1:0] TMO_ZERO = {TMO_WIDTH{1'b0}};
    localparam logic [TMO_WIDTH-1:0] TMO_ONE  = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

    logic [TMO_WIDTH-1:0] tmo_len_r;
    logic [TMO_WIDTH-1:0] wd_cnt_r;
    logic                 err_r;
    logic                 wd_in_wait_s;
    logic                 wd_stalled_s;

    // Watchdog trips on the limit-th handshake wait cycle without progress
    always_comb begin
        wd_in_wait_s = (state_r == ST_WAIT_ACK) || (state_r == ST_WAIT_DONE);
        wd_stalled_s = ((state_r == ST_WAIT_ACK) && fire_if.FIRE_DONE) ||
                       ((state_r == ST_WAIT_DONE) && !fire_if.FIRE_DONE);
        wd_trip_s    = wd_stalled_s && (tmo_len_r != TMO_ZERO) &&
                       (wd_cnt_r == (tmo_len_r - TMO_ONE));
    end

    // Watchdog limit latch, per-shot wait counter and sticky error flag
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            tmo_len_r <= TMO_ZERO;
            wd_cnt_r  <= TMO_ZERO;
            err_r     <= 1'b0;
        end else if (state_r == ST_ARM) begin
            tmo_len_r <= TMO_LENGTH;
            wd_cnt_r  <= TMO_ZERO;
            err_r     <= 1'b0;
        end else if (state_r == ST_FIRE) begin
            wd_cnt_r <= TMO_ZERO;
        end else if (wd_trip_s) begin
            err_r <= 1'b1;
        end else if (wd_in_wait_s) begin
            wd_cnt_r <= wd_cnt_r + TMO_ONE;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign SEQ_ERR = err_r;
`else
    logic tmo_unused_s;

    assign wd_trip_s    = 1'b0;
    assign SEQ_ERR      = 1'b0;
    assign tmo_unused_s = ^TMO_LENGTH;
`endif

    assign fire_if.FIRE_START = fire_start_r;
    assign fire_if.CH_SEL     = ch_sel_s;
    assign fire_if.AVG_IDX    = avg_idx_s;
    assign SEQ_BUSY           = busy_r;
    assign SEQ_DONE           = done_r;
    assign SEQ_ABORTED        = aborted_r;

endmodule

// File: tb/tb_us_scan_sequencer.sv
// Self-checking bench for us_scan_sequencer. A behavioural firing-FSM model
// answers each FIRE_START; a monitor logs shots, FIRE_DONE rises and done
// pulses; expectations come from the nested channel/average loop and the
// shot timing rules (first shot 2 cycles after start, DONE rise to next
// FIRE_START = PRI+2, etc.).
module tb_us_scan_sequencer;

    localparam int CH_W  = 4;
    localparam int AVG_W = 8;
    localparam int PRI_W = 32;
    localparam int TMO_W = 32;

    typedef struct {
        int ch;
        int avg;
        int cyc;
    } fire_t;

    logic              CLK;
    logic              RESET_n;
    logic              SEQ_START;
    logic              SEQ_ABORT;
    logic [CH_W-1:0]   NUM_CH;
    logic [AVG_W-1:0]  AVG_COUNT;
    logic [PRI_W-1:0]  PRI_LENGTH;
    logic [TMO_W-1:0]  TMO_LENGTH;
    logic              SEQ_BUSY;
    logic              SEQ_DONE;
    logic              SEQ_ABORTED;
    logic              SEQ_ERR;

    us_scan_sequencer_if #(.CH_WIDTH(CH_W), .AVG_WIDTH(AVG_W)) fire_if ();

    us_scan_sequencer dut (
        .CLK         (CLK),
        .RESET_n     (RESET_n),
        .SEQ_START   (SEQ_START),
        .SEQ_ABORT   (SEQ_ABORT),
        .NUM_CH      (NUM_CH),
        .AVG_COUNT   (AVG_COUNT),
        .PRI_LENGTH  (PRI_LENGTH),
        .TMO_LENGTH  (TMO_LENGTH),
        .fire_if     (fire_if),
        .SEQ_BUSY    (SEQ_BUSY),
        .SEQ_DONE    (SEQ_DONE),
        .SEQ_ABORTED (SEQ_ABORTED),
        .SEQ_ERR     (SEQ_ERR)
    );

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    busy_len = 3;
    bit    stuck    = 1'b0;
    fire_t fire_q[$];
    int    rise_q[$];
    int    done_cnt = 0;
    int    done_cyc = 0;
    logic  done_ab  = 1'b0;
    logic  done_err = 1'b0;
    logic  prev_fd  = 1'b1;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
        end
    end

    // Monitor: log shots, FIRE_DONE rises and done pulses mid-cycle
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET_n === 1'b1) begin
                if (fire_if.FIRE_START === 1'b1)
                    fire_q.push_back('{int'(fire_if.CH_SEL), int'(fire_if.AVG_IDX), cyc});
                if (prev_fd === 1'b0 && fire_if.FIRE_DONE === 1'b1)
                    rise_q.push_back(cyc);
                if (SEQ_DONE === 1'b1) begin
                    done_cnt = done_cnt + 1;
                    done_cyc = cyc;
                    done_ab  = SEQ_ABORTED;
                    done_err = SEQ_ERR;
                end
            end
            prev_fd = fire_if.FIRE_DONE;
        end
    end

    // Firing FSM model: DONE drops the cycle after FIRE_START, stays low busy_len cycles
    initial begin
        fire_if.FIRE_DONE = 1'b1;
        forever begin
            @(negedge CLK);
            if (fire_if.FIRE_START === 1'b1 && !stuck) begin
                @(posedge CLK);
                #1 fire_if.FIRE_DONE = 1'b0;
                repeat (busy_len) @(posedge CLK);
                #1 fire_if.FIRE_DONE = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_fire_start"}, fire_if.FIRE_START, 0);
        check({pfx, "_ch_sel"},     fire_if.CH_SEL, 0);
        check({pfx, "_avg_idx"},    fire_if.AVG_IDX, 0);
        check({pfx, "_busy"},       SEQ_BUSY, 0);
        check({pfx, "_done"},       SEQ_DONE, 0);
        check({pfx, "_aborted"},    SEQ_ABORTED, 0);
        check({pfx, "_err"},        SEQ_ERR, 0);
    endtask

    task automatic start_scan(input int n, input int a, input int p, input int t,
                              output int start_cyc);
        @(negedge CLK);
        NUM_CH     = CH_W'(n);
        AVG_COUNT  = AVG_W'(a);
        PRI_LENGTH = PRI_W'(p);
        TMO_LENGTH = TMO_W'(t);
        SEQ_START  = 1'b1;
        start_cyc  = cyc;
        @(negedge CLK);
        SEQ_START  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET_n = 1'b0;
        @(negedge CLK);
        RESET_n = 1'b1;
    endtask

    // One complete scan; abort_at >= 0 aborts during WAIT_DONE of that shot
    task automatic run_scan(input int n, input int a, input int p, input int b, input int abort_at);
        int start_cyc;
        int base_done;
        int exp_fires;
        int exp_done;
        int last;
        bit sent;
        sent = 1'b0;
        fire_q.delete();
        rise_q.delete();
        base_done = done_cnt;
        busy_len  = b;
        start_scan(n, a, p, 0, start_cyc);
        for (int i = 0; i < 3000 && done_cnt == base_done; i++) begin
            @(negedge CLK);
            #1;
            SEQ_ABORT = 1'b0;
            if (abort_at >= 0 && !sent && fire_q.size() == abort_at + 1 &&
                fire_if.FIRE_DONE === 1'b0 && cyc >= fire_q[abort_at].cyc + 2) begin
                SEQ_ABORT = 1'b1;
                sent = 1'b1;
            end
        end
        SEQ_ABORT = 1'b0;
        check("done_seen", done_cnt - base_done, 1);
        repeat (p + 8) @(negedge CLK);
        #1;
        if (n == 0 || a == 0) exp_fires = 0;
        else if (abort_at >= 0) exp_fires = abort_at + 1;
        else exp_fires = n * a;
        check("fire_count", fire_q.size(), exp_fires);
        check("done_pulses", done_cnt - base_done, 1);
        for (int k = 0; k < fire_q.size() && k < exp_fires; k++) begin
            check("ch_sel", fire_q[k].ch, k / a);
            check("avg_idx", fire_q[k].avg, k % a);
        end
        if (fire_q.size() > 0)
            check("first_latency", fire_q[0].cyc - start_cyc, 2);
        for (int k = 1; k < fire_q.size() && k <= rise_q.size(); k++)
            check("pri_gap", fire_q[k].cyc - rise_q[k-1], p + 2);
        if (exp_fires == 0) begin
            check("done_latency", done_cyc - start_cyc, 2);
        end else begin
            check("rise_count", rise_q.size() >= exp_fires, 1);
            last = exp_fires - 1;
            if (rise_q.size() > last) begin
                exp_done = (abort_at >= 0) ? rise_q[last] + 1 : rise_q[last] + p + 2;
                check("done_cycle", done_cyc, exp_done);
            end
        end
        check("aborted_at_done", done_ab, (abort_at >= 0) ? 1 : 0);
        check("aborted_sticky", SEQ_ABORTED, (abort_at >= 0) ? 1 : 0);
        check("err_at_done", done_err, 0);
        check("busy_after", SEQ_BUSY, 0);
    endtask

    initial begin
        int sc;
        int base;
        bit found;
        SEQ_START  = 1'b0;
        SEQ_ABORT  = 1'b0;
        NUM_CH     = '0;
        AVG_COUNT  = '0;
        PRI_LENGTH = '0;
        TMO_LENGTH = '0;
        RESET_n    = 1'b1;
        #2 RESET_n = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check_outputs_zero("reset");
        @(negedge CLK);
        RESET_n = 1'b1;

        // Directed scans
        run_scan(3, 2, 10, 20, -1);
        run_scan(0, 2, 3, 3, -1);
        run_scan(2, 0, 3, 3, -1);
        run_scan(2, 1, 0, 4, -1);
        run_scan(3, 2, 4, 6, 1);

        // Randomized scans
        repeat (4) begin
            run_scan(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                     int'($urandom_range(0, 6)), int'($urandom_range(1, 6)), -1);
        end

        // Reset asserted while waiting out the PRI of the third shot
        fire_q.delete();
        rise_q.delete();
        busy_len = 3;
        start_scan(3, 2, 10, 0, sc);
        for (int i = 0; i < 400 && rise_q.size() < 3; i++) @(negedge CLK);
        check("pri_rise_seen", rise_q.size() >= 3, 1);
        repeat (3) @(negedge CLK);
        #1;
        check("pri_mid_ch", fire_if.CH_SEL, 1);
        check("pri_mid_avg", fire_if.AVG_IDX, 0);
        check("pri_mid_busy", SEQ_BUSY, 1);
        RESET_n = 1'b0;
        #1;
        check_outputs_zero("rst_pri");
        @(negedge CLK);
        RESET_n = 1'b1;

        // Reset asserted during the FIRE cycle itself
        start_scan(2, 2, 2, 0, sc);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            #1;
            if (fire_if.FIRE_START === 1'b1) found = 1'b1;
        end
        check("fire_seen_before_rst", found, 1);
        RESET_n = 1'b0;
        #1;
        check_outputs_zero("rst_fire");
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (busy_len + 6) @(negedge CLK);

        // Fresh scan after reset restarts at channel 0
        run_scan(2, 2, 1, 2, -1);

        // Firing FSM never leaves idle
        stuck = 1'b1;
        fire_q.delete();
        base = done_cnt;
        start_scan(1, 1, 3, 50, sc);
        for (int i = 0; i < 300 && done_cnt == base; i++) begin
            @(negedge CLK);
            #1;
        end
`ifdef SEQ_TIMEOUT_EN
        check("wd_done_seen", done_cnt - base, 1);
        check("wd_fire_count", fire_q.size(), 1);
        if (fire_q.size() == 1)
            check("wd_latency", done_cyc - fire_q[0].cyc, 51);
        check("wd_err_at_done", done_err, 1);
        check("wd_err_sticky", SEQ_ERR, 1);
`else
        check("wd_no_done", done_cnt - base, 0);
        check("wd_err_zero", SEQ_ERR, 0);
        check("wd_still_busy", SEQ_BUSY, 1);
`endif
        pulse_reset();
        stuck = 1'b0;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/us_scan_sequencer.md
Name: us_scan_sequencer

Overview:
Top-level scan scheduler that drives the single-shot ultrasound firing FSM (TX_EN plus ADC acquisition window) once per shot. It steps through NUM_CH transducer channels and fires each channel AVG_COUNT times for averaging. It inserts a programmable pulse-repetition interval (PRI) between shots and reports sequence completion to the host or SoC-less control logic.

Parameters:
CH_WIDTH, 4, width of channel index and channel count
AVG_WIDTH, 8, width of averaging count and index
PRI_WIDTH, 32, width of PRI cycle counter
TMO_WIDTH, 32, width of watchdog counter (used only with SEQ_TIMEOUT_EN)

Ports:
CLK  input  1  system clock
RESET_n  input  1  asynchronous, active-low reset
SEQ_START  input  1  level/pulse; sampled in IDLE only
SEQ_ABORT  input  1  request to stop after current shot
NUM_CH  input  CH_WIDTH  channels per scan; latched at start
AVG_COUNT  input  AVG_WIDTH  shots per channel; latched at start
PRI_LENGTH  input  PRI_WIDTH  idle cycles between shots; latched at start
TMO_LENGTH  input  TMO_WIDTH  FIRE_DONE watchdog limit; latched at start
FIRE_START  output  1  one-cycle start pulse to firing FSM
FIRE_DONE  input  1  firing FSM DONE (high when idle, low while busy)
CH_SEL  output  CH_WIDTH  active channel, stable for the whole shot
AVG_IDX  output  AVG_WIDTH  shot index within current channel
SEQ_BUSY  output  1  high from ARM through FINISH
SEQ_DONE  output  1  one-cycle pulse at end of sequence
SEQ_ABORTED  output  1  sticky; set on abort-terminated sequence
SEQ_ERR  output  1  sticky; watchdog fault

Behaviour:
- Reset values: FIRE_START=0, CH_SEL=0, AVG_IDX=0, SEQ_BUSY=0, SEQ_DONE=0, SEQ_ABORTED=0, SEQ_ERR=0, state=IDLE, all counters 0.
- IDLE: when SEQ_START=1, go to ARM.
- ARM: latch NUM_CH, AVG_COUNT, PRI_LENGTH and TMO_LENGTH. Clear SEQ_ABORTED and SEQ_ERR. Set CH_SEL=0 and AVG_IDX=0. Assert SEQ_BUSY.
  - If NUM_CH=0 or AVG_COUNT=0, go to FINISH with no shot fired.
  - Otherwise go to FIRE.
- FIRE: FIRE_START=1 for exactly this cycle, then go to WAIT_ACK. Latency: SEQ_START sampled in cycle n gives FIRE_START in cycle n+2.
- WAIT_ACK: wait for FIRE_DONE=0 (firing FSM has left idle), then go to WAIT_DONE.
- WAIT_DONE: wait for FIRE_DONE=1, then go to PRI. If PRI_LENGTH=0, go directly to NEXT.
- PRI: stay exactly PRI_LENGTH cycles, using a down-counter loaded on entry, then go to NEXT.
- NEXT (1 cycle): advance the indices, averaging loop inner.
  - If AVG_IDX<AVG_COUNT-1: AVG_IDX+1.
  - Else: AVG_IDX=0 and CH_SEL+1.
  - If the last shot is done (CH_SEL=NUM_CH-1 and AVG_IDX=AVG_COUNT-1): go to FINISH. CH_SEL and AVG_IDX hold their last values and do not wrap.
  - Otherwise go to FIRE.
- FINISH (1 cycle): SEQ_DONE=1, SEQ_BUSY drops the next cycle, go to IDLE.
- CH_SEL and AVG_IDX change only in ARM and NEXT. They are stable from FIRE through PRI.
- Abort:
  - SEQ_ABORT sampled high in any non-IDLE state sets an internal abort flag.
  - In FIRE, WAIT_ACK or WAIT_DONE: the current shot completes (the firing FSM cannot be cancelled), then go straight to FINISH and skip PRI.
  - In PRI or NEXT: go to FINISH on the next cycle.
  - SEQ_ABORTED=1 at FINISH.
  - SEQ_ABORT in IDLE is ignored.
- SEQ_START while busy: ignored. SEQ_START held high after FINISH: a new sequence starts from IDLE, which is a legal back-to-back scan.
- Simultaneous abort and last shot completing in NEXT: FINISH with SEQ_ABORTED=0.
- Reset mid-operation: all outputs return to reset values immediately; FIRE_START deasserts asynchronously.
- Arithmetic: comparisons use latched values minus 1 at full width, no sign extension. The PRI counter is PRI_WIDTH bits.

Optional Feature:
Macro SEQ_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT_ACK plus WAIT_DONE. If the count reaches TMO_LENGTH (TMO_LENGTH=0 disables the check), set SEQ_ERR=1 and go to FINISH, which pulses SEQ_DONE.
- Undefined: no watchdog logic; TMO_LENGTH is unused; SEQ_ERR is tied to 0.

Decomposition:
- Package us_seq_pkg holds:
  - state encoding as one-hot localparams (IDLE, ARM, FIRE, WAIT_ACK, WAIT_DONE, PRI, NEXT, FINISH);
  - default widths.
- One natural sub-module, us_seq_index_ctr: the nested CH_SEL/AVG_IDX counter with a last-shot flag, driven by load and advance strobes.
- The PRI and watchdog counters stay inline.

Test Plan:
- NUM_CH=3, AVG_COUNT=2, PRI_LENGTH=10, model FSM busy 20 cycles:
  - 6 FIRE_START pulses;
  - (CH_SEL,AVG_IDX) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1);
  - FIRE_DONE rise to next FIRE_START = 12 cycles;
  - single SEQ_DONE pulse.
- NUM_CH=0 or AVG_COUNT=0 -> no FIRE_START; SEQ_DONE exactly 2 cycles after SEQ_START sampled.
- PRI_LENGTH=0, NUM_CH=2, AVG_COUNT=1 -> FIRE_DONE rise to next FIRE_START = 2 cycles.
- SEQ_ABORT pulsed mid-WAIT_DONE of shot 2 of 6 -> shot 2 completes; no further FIRE_START; SEQ_DONE=1; SEQ_ABORTED=1.
- RESET_n low during PRI -> all outputs 0 in the same cycle; new SEQ_START after release restarts at CH_SEL=0.
- SEQ_TIMEOUT_EN defined, TMO_LENGTH=50, FIRE_DONE stuck high after FIRE_START -> SEQ_ERR=1 and SEQ_DONE after 50 cycles. Without the macro, the sequencer waits indefinitely and SEQ_ERR stays 0.
